// File: rtl/cve2_obi_mem_responder.sv
// OBI-style memory responder: word-addressed single-port array, grant with back-pressure,
// in-order fixed-latency responses with an error flag for misaligned or out-of-range accesses.
module cve2_obi_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] AddrBase       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        stall_i
);
    localparam int unsigned IdxW      = $clog2(MemWords);
    localparam int unsigned CntW      = $clog2(MaxOutstanding + 1);
    localparam logic [31:0] SpanBytes = 32'(MemWords * 4);

    logic [31:0]        mem [MemWords];
    logic [31:0]        offset;
    logic [IdxW-1:0]    idx;
    logic               access_ok;
    logic               grant;
    logic [31:0]        resp_data;
    logic               resp_err;
    logic [CntW-1:0]    outstanding_q;
    logic [Latency-1:0] pipe_valid_q;
    logic [Latency-1:0] pipe_err_q;
    logic [31:0]        pipe_data_q [Latency];

    // Unsigned subtraction: addresses below the base wrap high and fail the range check.
    assign offset    = addr_i - AddrBase;
    assign idx       = offset[IdxW+1:2];
    assign access_ok = (addr_i[1:0] == 2'b00) && (offset < SpanBytes);

    // A retiring response frees a slot in the same cycle.
    assign gnt_o = req_i & ~stall_i & ((outstanding_q < CntW'(MaxOutstanding)) | rvalid_o);
    assign grant = req_i & gnt_o;

    always_comb begin
        resp_data = '0;
        resp_err  = 1'b0;
        if (!access_ok) begin
            resp_err = 1'b1;
        end else if (!we_i) begin
            resp_data = mem[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant && access_ok && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid_q <= '0;
            pipe_err_q   <= '0;
            for (int i = 0; i < Latency; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= grant;
            pipe_err_q[0]   <= grant & resp_err;
            pipe_data_q[0]  <= grant ? resp_data : 32'h0;
            for (int i = 1; i < Latency; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_err_q[i]   <= pipe_err_q[i-1];
                pipe_data_q[i]  <= pipe_data_q[i-1];
            end
        end
    end

    assign rvalid_o = pipe_valid_q[Latency-1];
    assign err_o    = pipe_err_q[Latency-1];
    assign rdata_o  = pipe_data_q[Latency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else if (grant && !rvalid_o) begin
            outstanding_q <= outstanding_q + 1'b1;
        end else if (!grant && rvalid_o) begin
            outstanding_q <= outstanding_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// Bench for cve2_obi_mem_responder: two configurations checked every cycle against a
// queue-based response model, plus directed scenarios and randomized traffic.
module tb_cve2_obi_mem_responder;
    localparam logic [31:0] BASE_A = 32'h0000_1000;
    localparam int MW_A = 64, LAT_A = 1, MAXO_A = 2;
    localparam logic [31:0] BASE_B = 32'h0000_0000;
    localparam int MW_B = 16, LAT_B = 4, MAXO_B = 2;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [2];
    logic        we [2];
    logic        stall [2];
    logic        gnt [2];
    logic        rvalid [2];
    logic        err [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [3:0]  be [2];

    resp_t       q0 [$];
    resp_t       q1 [$];
    logic [31:0] mm [2][64];
    logic        exp_gnt [2];
    logic [31:0] last_rdata [2];
    logic        last_err [2];
    int          ga_cyc [$];
    int          gb_cyc [$];
    int          rv_cyc_a [$];
    int          rv_cyc_b [$];
    int          cyc = 0;
    int          passed = 0;
    int          fails = 0;
    int          total = 0;

    always #5 clk = ~clk;

    cve2_obi_mem_responder #(.MemWords(MW_A), .AddrBase(BASE_A), .Latency(LAT_A), .MaxOutstanding(MAXO_A)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
        .stall_i(stall[0])
    );

    cve2_obi_mem_responder #(.MemWords(MW_B), .AddrBase(BASE_B), .Latency(LAT_B), .MaxOutstanding(MAXO_B)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
        .stall_i(stall[1])
    );

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? BASE_A : BASE_B;
    endfunction
    function automatic int mw_of(input int k);
        return (k == 0) ? MW_A : MW_B;
    endfunction
    function automatic int lat_of(input int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction
    function automatic int maxo_of(input int k);
        return (k == 0) ? MAXO_A : MAXO_B;
    endfunction

    function automatic logic [31:0] rand_addr(input int k);
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 7) return base_of(k) + 32'(4 * $urandom_range(0, mw_of(k) - 1));
        else if (sel == 7) return base_of(k) + 32'(mw_of(k) * 4) + 32'(4 * $urandom_range(0, 3));
        else if (sel == 8) return base_of(k) + 32'(4 * $urandom_range(0, mw_of(k) - 1)) + 32'($urandom_range(1, 3));
        else return base_of(k) - 32'(4 * $urandom_range(1, 4));
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: a transaction is accepted, its effect applied to the model array, and a
    // response queued for delivery exactly lat cycles later.
    task automatic model_grant(input int k);
        resp_t       r;
        logic [31:0] off;
        int          w;
        off    = addr[k] - base_of(k);
        r.due  = cyc + lat_of(k);
        r.data = 32'h0;
        r.err  = !(addr[k][1:0] == 2'b00 && off < 32'(mw_of(k) * 4));
        if (!r.err) begin
            w = int'(off >> 2);
            if (we[k]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[k][b]) mm[k][w][8*b +: 8] = wdata[k][8*b +: 8];
                end
            end else begin
                r.data = mm[k][w];
            end
        end
        if (k == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    task automatic check_inst(input int k);
        resp_t h;
        int    n;
        logic  exp_rv;
        logic  g;
        n      = (k == 0) ? q0.size() : q1.size();
        exp_rv = 1'b0;
        if (n > 0) begin
            if (k == 0) h = q0[0];
            else h = q1[0];
            exp_rv = (h.due == cyc);
        end
        g = req[k] & ~stall[k] & ((n < maxo_of(k)) | exp_rv);
        chk1($sformatf("gnt[%0d]@%0d", k, cyc), gnt[k], g);
        chk1($sformatf("rvalid[%0d]@%0d", k, cyc), rvalid[k], exp_rv);
        if (exp_rv) begin
            chk32($sformatf("rdata[%0d]@%0d", k, cyc), rdata[k], h.data);
            chk1($sformatf("err[%0d]@%0d", k, cyc), err[k], h.err);
            last_rdata[k] = rdata[k];
            last_err[k]   = err[k];
            if (k == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
        if (rvalid[k] === 1'b1) begin
            if (k == 0) rv_cyc_a.push_back(cyc);
            else rv_cyc_b.push_back(cyc);
        end
        if (gnt[k] === 1'b1) begin
            if (k == 0) ga_cyc.push_back(cyc);
            else gb_cyc.push_back(cyc);
        end
        exp_gnt[k] = g;
        if (g) model_grant(k);
    endtask

    task automatic tick();
        #4;
        check_inst(0);
        check_inst(1);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_txn(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, output int gc);
        int now;
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        gc = -1;
        for (int i = 0; i < 50 && gc < 0; i++) begin
            now = cyc;
            tick();
            if (exp_gnt[k]) gc = now;
        end
        req[k] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q0.size() > 0 || q1.size() > 0); i++) tick();
        tick();
    endtask

    task automatic do_reset();
        req[0] = 1'b0;
        req[1] = 1'b0;
        rst_n  = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("rst_rvalid[%0d]", k), rvalid[k], 1'b0);
            chk1($sformatf("rst_err[%0d]", k), err[k], 1'b0);
            chk32($sformatf("rst_rdata[%0d]", k), rdata[k], 32'h0);
        end
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
    endtask

    initial begin
        int g1, g2, t0, idx;
        int exp_g [4];
        int exp_r [4];
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; stall[k] = 1'b0; addr[k] = 32'h0;
            wdata[k] = 32'h0; be[k] = 4'h0; exp_gnt[k] = 1'b0;
            last_rdata[k] = 32'h0; last_err[k] = 1'b0;
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            chk1($sformatf("reset_gnt[%0d]", k), gnt[k], 1'b0);
            chk1($sformatf("reset_rvalid[%0d]", k), rvalid[k], 1'b0);
            chk32($sformatf("reset_rdata[%0d]", k), rdata[k], 32'h0);
            chk1($sformatf("reset_err[%0d]", k), err[k], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int w = 0; w < MW_A; w++) do_txn(0, 1'b1, BASE_A + 32'(4 * w), 4'hF, $urandom(), g1);
        for (int w = 0; w < MW_B; w++) do_txn(1, 1'b1, BASE_B + 32'(4 * w), 4'hF, $urandom(), g1);
        drain();

        // Write then read-back in consecutive cycles on the latency-1 instance.
        rv_cyc_a.delete();
        do_txn(0, 1'b1, BASE_A + 32'h10, 4'hF, 32'hDEADBEEF, g1);
        do_txn(0, 1'b0, BASE_A + 32'h10, 4'h0, 32'h0, g2);
        drain();
        chk_int("wr_rd_gnt_spacing", g2 - g1, 1);
        chk_int("wr_rvalid_cycle", (rv_cyc_a.size() > 0) ? rv_cyc_a[0] : -1, g1 + 1);
        chk_int("rd_rvalid_cycle", (rv_cyc_a.size() > 1) ? rv_cyc_a[1] : -1, g2 + 1);
        chk32("wr_rd_data", last_rdata[0], 32'hDEADBEEF);

        do_txn(0, 1'b1, BASE_A + 32'h14, 4'hF, 32'h11223344, g1);
        do_txn(0, 1'b1, BASE_A + 32'h14, 4'b0101, 32'hAABBCCDD, g1);
        do_txn(0, 1'b0, BASE_A + 32'h14, 4'h0, 32'h0, g1);
        drain();
        chk32("be_merge_data", last_rdata[0], 32'h11BB33DD);
        chk1("be_merge_err", last_err[0], 1'b0);

        do_txn(0, 1'b0, BASE_A + 32'(MW_A * 4), 4'h0, 32'h0, g1);
        drain();
        chk1("oob_err", last_err[0], 1'b1);
        chk32("oob_data", last_rdata[0], 32'h0);
        do_txn(0, 1'b0, BASE_A + 32'h2, 4'h0, 32'h0, g1);
        drain();
        chk1("misaligned_err", last_err[0], 1'b1);
        chk32("misaligned_data", last_rdata[0], 32'h0);
        do_txn(0, 1'b0, 32'h0000_0FFC, 4'h0, 32'h0, g1);
        drain();
        chk1("below_base_err", last_err[0], 1'b1);
        chk32("below_base_data", last_rdata[0], 32'h0);
        do_txn(0, 1'b1, BASE_A + 32'(MW_A * 4) + 32'h14, 4'hF, 32'hFFFF_FFFF, g1);
        do_txn(0, 1'b1, BASE_A + 32'h16, 4'hF, 32'h0, g1);
        do_txn(0, 1'b0, BASE_A + 32'h14, 4'h0, 32'h0, g1);
        drain();
        chk32("array_unchanged_after_errors", last_rdata[0], 32'h11BB33DD);

        // Outstanding limit on the latency-4 instance with req held across four reads.
        gb_cyc.delete();
        rv_cyc_b.delete();
        exp_g = '{0, 1, 4, 5};
        exp_r = '{4, 5, 8, 9};
        t0 = cyc;
        idx = 0;
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = BASE_B;
        for (int i = 0; i < 30 && idx < 4; i++) begin
            tick();
            if (exp_gnt[1]) begin
                idx++;
                addr[1] = BASE_B + 32'(4 * idx);
            end
        end
        req[1] = 1'b0;
        drain();
        for (int j = 0; j < 4; j++) begin
            chk_int($sformatf("limit_gnt_cycle%0d", j), (j < gb_cyc.size()) ? gb_cyc[j] - t0 : -1, exp_g[j]);
            chk_int($sformatf("limit_rvalid_cycle%0d", j), (j < rv_cyc_b.size()) ? rv_cyc_b[j] - t0 : -1, exp_r[j]);
        end

        // Back-pressure: three stalled cycles with req held, then grant.
        ga_cyc.delete();
        rv_cyc_a.delete();
        t0 = cyc;
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'h0; addr[0] = BASE_A + 32'h14;
        stall[0] = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        stall[0] = 1'b0;
        tick();
        req[0] = 1'b0;
        drain();
        chk_int("stall_gnt_count", ga_cyc.size(), 1);
        chk_int("stall_gnt_cycle", (ga_cyc.size() > 0) ? ga_cyc[0] - t0 : -1, 3);
        chk_int("stall_rvalid_cycle", (rv_cyc_a.size() > 0) ? rv_cyc_a[0] - t0 : -1, 3 + LAT_A);
        chk32("stall_rdata", last_rdata[0], 32'h11BB33DD);

        // Reset with two reads in flight on the latency-4 instance.
        do_txn(1, 1'b1, BASE_B + 32'h8, 4'hF, 32'hCAFEF00D, g1);
        drain();
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE_B + 32'h8;
        tick();
        addr[1] = BASE_B + 32'hC;
        tick();
        do_reset();
        rv_cyc_b.delete();
        for (int i = 0; i < 8; i++) tick();
        chk_int("rvalid_after_reset", rv_cyc_b.size(), 0);
        gb_cyc.delete();
        t0 = cyc;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE_B + 32'h8;
        tick();
        tick();
        req[1] = 1'b0;
        drain();
        chk_int("post_reset_gnt_count", gb_cyc.size(), 2);
        chk_int("post_reset_gnt_cycle", (gb_cyc.size() > 1) ? gb_cyc[1] - t0 : -1, 1);
        chk32("post_reset_retained", last_rdata[1], 32'hCAFEF00D);

        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!req[k] || exp_gnt[k]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[k]   = 1'b1;
                        we[k]    = 1'($urandom_range(0, 1));
                        be[k]    = 4'($urandom_range(0, 15));
                        wdata[k] = $urandom();
                        addr[k]  = rand_addr(k);
                    end else begin
                        req[k] = 1'b0;
                    end
                end
                stall[k] = ($urandom_range(0, 4) == 0);
            end
            tick();
        end
        req[0] = 1'b0; req[1] = 1'b0; stall[0] = 1'b0; stall[1] = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
